dmem_responder: RTL



---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_wait_timer.sv | 30 +++
 rtl/dmem_responder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Imported by dmem_responder and dmem_wait_timer.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_CONFLICT = 2'b11;

    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2B;

    localparam int TMR_W = $clog2(16);

endpackage

// File: rtl/dmem_wait_timer.sv
// Loadable down-counter timing the SRAM access latency.
// Ports: clk, rst_n, load/load_val, dec; done is high while count==1.
module dmem_wait_timer
    import dmem_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == W'(1));

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one lw/sw at a time to a fixed-latency SRAM,
// stalling the core until done; flags bad requests; counts accesses/stalls.
// Ports: clk, rst_n; core side mem_read/mem_write/addr/wdata -> rdata/stall/
// err/err_code; SRAM side sram_en/we/addr/wdata, sram_rdata; access_cnt,
// stall_cnt performance counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    output logic [CNT_W-1:0]  access_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [TMR_W-1:0] LAT_M1 = TMR_W'(LATENCY - 1);

    state_t      state;
    state_t      state_nx;
    logic        req;
    logic        bad;
    logic        issue;
    logic        wr_q;
    logic        tmr_done;
    logic [1:0]  chk_code;
    logic [31:0] hold;

    // Gating with rst_n keeps the SRAM quiet the instant reset asserts,
    // even though the core may still be presenting its request.
    assign req = (mem_read | mem_write) & rst_n;

    always_comb begin
        chk_code = ERR_NONE;
        if (mem_read && mem_write) begin
            chk_code = ERR_CONFLICT;
        end else if (addr[1:0] != 2'b00) begin
            chk_code = ERR_MISALIGN;
        end else if (addr[31:ADDR_W+2] != '0) begin
            chk_code = ERR_RANGE;
        end
    end

    assign bad   = (chk_code != ERR_NONE);
    assign issue = (state == IDLE) && req && !bad;

    dmem_wait_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (issue),
        .load_val (LAT_M1),
        .dec      (state == WAIT),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_nx = (LATENCY > 1) ? WAIT : DONE;
                end
            end
            WAIT: begin
                if (tmr_done) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        stall    = 1'b0;
        err      = 1'b0;
        err_code = ERR_NONE;
        sram_en  = 1'b0;
        sram_we  = 1'b0;
        rdata    = hold;
        case (state)
            IDLE: begin
                if (req && bad) begin
                    err      = 1'b1;
                    err_code = chk_code;
                    rdata    = '0;
                end else if (req) begin
                    sram_en = 1'b1;
                    sram_we = mem_write;
                    stall   = 1'b1;
                end
            end
            WAIT: stall = 1'b1;
            DONE: begin
                if (!wr_q) begin
                    rdata = sram_rdata;
                end
            end
            default: ;
        endcase
    end

    assign sram_addr  = addr[ADDR_W+1:2];
    assign sram_wdata = wdata;

    // Direction is latched at issue so a request dropped mid-access
    // still completes as the original read or write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= 1'b0;
            hold <= '0;
        end else begin
            if (issue) begin
                wr_q <= mem_write;
            end
            if (state == DONE && !wr_q) begin
                hold <= sram_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            access_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (state == DONE && access_cnt != '1) begin
                access_cnt <= access_cnt + CNT_W'(1);
            end
            if (stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule
